// File: rtl/shift_add_mult_control.sv
// Shift-and-add multiplier controller.
// Five-state ASM (IDLE, LOAD, ADD, SHIFT, DONE) that sequences the multiplicand,
// multiplier shift register and accumulator of a shift-and-add datapath. The
// state is decoded into one-hot t0..t4 plus the datapath strobes. The operation
// is requested with a level start/done handshake.

module shift_add_mult_control #(
    parameter int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             q0,
    output logic             t0,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             load_en,
    output logic             clr_acc,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Index of the final add/shift pass; iter saturates here instead of wrapping.
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    // Next-state and iteration-counter logic for the ASM chart.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                iter_d  = '0;
                state_d = abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                state_d = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                // Abort wins over both exits and leaves iter frozen.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (iter_q == ITER_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                    iter_d  = iter_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Level handshake: hold the result until start is dropped.
                if (!start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Output decode from the registered state; add_en is Mealy on q0.
    always_comb begin
        t0       = (state_q == S_IDLE);
        t1       = (state_q == S_LOAD);
        t2       = (state_q == S_ADD);
        t3       = (state_q == S_SHIFT);
        t4       = (state_q == S_DONE);
        load_en  = t1;
        clr_acc  = t1;
        add_en   = t2 & q0;
        shift_en = t3;
        busy     = t1 | t2 | t3;
        done     = t4;
        iter     = iter_q;
    end

endmodule

// File: tb/tb_shift_add_mult_control.sv
// Directed bench for shift_add_mult_control: a WIDTH=8 instance exercised
// through reset, full operations, the DONE handshake, abort and reset
// mid-operation, plus a WIDTH=2 instance for the short-latency case.

module tb_shift_add_mult_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort, q0;
    logic       t0, t1, t2, t3, t4;
    logic       load_en, clr_acc, add_en, shift_en, busy, done;
    logic [2:0] iter;

    logic       start2, q02;
    logic       t0_2, t1_2, t2_2, t3_2, t4_2;
    logic       load_en2, clr_acc2, add_en2, shift_en2, busy2, done2;
    logic [0:0] iter2;

    shift_add_mult_control #(.WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .q0(q0),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .load_en(load_en), .clr_acc(clr_acc), .add_en(add_en), .shift_en(shift_en),
        .busy(busy), .done(done), .iter(iter)
    );

    shift_add_mult_control #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .q0(q02),
        .t0(t0_2), .t1(t1_2), .t2(t2_2), .t3(t3_2), .t4(t4_2),
        .load_en(load_en2), .clr_acc(clr_acc2), .add_en(add_en2), .shift_en(shift_en2),
        .busy(busy2), .done(done2), .iter(iter2)
    );

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int add_cnt = 0, shift_cnt = 0, load_cnt = 0, done_cnt = 0, shift_cnt2 = 0;

    // Strobe counts as seen by the datapath on each rising edge.
    always @(posedge clk) begin
        add_cnt    <= add_cnt + int'(add_en);
        shift_cnt  <= shift_cnt + int'(shift_en);
        load_cnt   <= load_cnt + int'(load_en);
        done_cnt   <= done_cnt + int'(done);
        shift_cnt2 <= shift_cnt2 + int'(shift_en2);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        edges++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int e0, a0, s0, l0, d0, n;
        logic [7:0] pat;

        reset = 1'b1; start = 1'b1; abort = 1'b0; q0 = 1'b0;
        start2 = 1'b0; q02 = 1'b1;

        // Reset for two cycles with start held high.
        tick();
        tick();
        chk1("rst_t0", t0, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkn("rst_iter", int'(iter), 0);
        chk1("rst_strobes", load_en | clr_acc | add_en | shift_en, 1'b0);
        chk1("rst_t0_w2", t0_2, 1'b1);
        reset = 1'b0;
        #1;
        chk1("rel_still_idle", t0, 1'b1);

        // Full operation, q0 constant 1.
        q0 = 1'b1;
        a0 = add_cnt; s0 = shift_cnt; l0 = load_cnt;
        tick();
        e0 = edges;
        chk1("t1_load", t1, 1'b1);
        chk1("t1_load_en", load_en, 1'b1);
        chk1("t1_clr_acc", clr_acc, 1'b1);
        chk1("t1_busy", busy, 1'b1);
        start = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk1("t1_add_state", t2, 1'b1);
            chk1("t1_add_en", add_en, 1'b1);
            chkn("t1_add_iter", int'(iter), i);
            tick();
            chk1("t1_shift_state", t3, 1'b1);
            chk1("t1_shift_en", shift_en, 1'b1);
            chk1("t1_shift_no_add", add_en, 1'b0);
            tick();
        end
        chk1("t1_done_state", t4, 1'b1);
        chk1("t1_done", done, 1'b1);
        chk1("t1_done_busy", busy, 1'b0);
        chkn("t1_done_iter", int'(iter), 7);
        chkn("t1_latency", edges - e0, 17);
        chkn("t1_add_count", add_cnt - a0, 8);
        chkn("t1_shift_count", shift_cnt - s0, 8);
        chkn("t1_load_count", load_cnt - l0, 1);
        tick();
        chk1("t1_back_idle", t0, 1'b1);

        // q0 pattern 1,0,1,1,0,0,0,1.
        pat = 8'b1000_1101;
        a0 = add_cnt; s0 = shift_cnt;
        start = 1'b1;
        tick();
        chk1("t2_load", t1, 1'b1);
        start = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            q0 = pat[i];
            #1;
            chk1("t2_add_en", add_en, pat[i]);
            chkn("t2_iter", int'(iter), i);
            tick();
            chk1("t2_shift_en", shift_en, 1'b1);
            tick();
        end
        chk1("t2_done", done, 1'b1);
        chkn("t2_add_count", add_cnt - a0, 4);
        chkn("t2_shift_count", shift_cnt - s0, 8);

        // Start held through DONE keeps done high; dropping it returns to IDLE.
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t3_hold_done", done, 1'b1);
            chk1("t3_hold_t4", t4, 1'b1);
        end
        start = 1'b0;
        tick();
        chk1("t3_drop_idle", t0, 1'b1);
        chk1("t3_drop_done", done, 1'b0);
        start = 1'b1;
        tick();
        chk1("t3_restart_load", t1, 1'b1);
        chk1("t3_restart_load_en", load_en, 1'b1);

        // Abort in the ADD of iteration 3.
        start = 1'b0; q0 = 1'b1;
        d0 = done_cnt;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk1("t4_add", t2, 1'b1);
            tick();
            tick();
        end
        chk1("t4_add3_state", t2, 1'b1);
        chkn("t4_add3_iter", int'(iter), 3);
        abort = 1'b1;
        #1;
        chk1("t4_abort_cycle_add_en", add_en, 1'b1);
        tick();
        abort = 1'b0;
        chk1("t4_abort_idle", t0, 1'b1);
        chkn("t4_abort_iter", int'(iter), 3);
        chk1("t4_abort_quiet", load_en | clr_acc | add_en | shift_en, 1'b0);
        a0 = add_cnt; s0 = shift_cnt;
        tick();
        tick();
        tick();
        chkn("t4_no_more_add", add_cnt - a0, 0);
        chkn("t4_no_more_shift", shift_cnt - s0, 0);
        chkn("t4_no_done", done_cnt - d0, 0);
        chk1("t4_stays_idle", t0, 1'b1);

        // Reset together with abort during the SHIFT of iteration 5.
        start = 1'b1;
        tick();
        chk1("t5_load", t1, 1'b1);
        chkn("t5_iter_frozen_in_load", int'(iter), 3);
        start = 1'b0;
        tick();
        chkn("t5_iter_cleared", int'(iter), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        tick();
        chk1("t5_shift5_state", t3, 1'b1);
        chkn("t5_shift5_iter", int'(iter), 5);
        reset = 1'b1; abort = 1'b1;
        tick();
        chk1("t5_rst_idle", t0, 1'b1);
        chkn("t5_rst_iter", int'(iter), 0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_quiet", load_en | clr_acc | add_en | shift_en, 1'b0);
        reset = 1'b0; abort = 1'b0;
        tick();
        chk1("t5_after_idle", t0, 1'b1);

        // WIDTH=2 instance: DONE five edges after the start-sampling edge.
        s0 = shift_cnt2;
        start2 = 1'b1;
        tick();
        chk1("w2_load", t1_2, 1'b1);
        start2 = 1'b0;
        n = 0;
        while (n < 20 && t4_2 !== 1'b1) begin
            tick();
            n++;
        end
        chkn("w2_latency", n, 5);
        chk1("w2_done", done2, 1'b1);
        chkn("w2_iter", int'(iter2), 1);
        chkn("w2_shift_count", shift_cnt2 - s0, 2);
        tick();
        chk1("w2_idle", t0_2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
